// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (op codes 7-10).
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        md_active,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DATA_W = 32;
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           op_p0;
  logic [DATA_W-1:0]    src_a_p0;
  logic [DATA_W-1:0]    src_b_p0;
  logic                 sgn_p0;
  logic [2*DATA_W-1:0]  prod_p0;
  logic [2*DATA_W-1:0]  quot_p0;
  logic [2*DATA_W-1:0]  res_p0;
  logic                 res_wr_p0;

  function automatic logic is_start(input logic [3:0] code);
    logic s;
    s = (code == OP_MULT) || (code == OP_MULTU) || (code == OP_DIV) || (code == OP_DIVU);
`ifdef MDU_MADD_EN
    s = s || (code == OP_MADD) || (code == OP_MADDU) || (code == OP_MSUB) || (code == OP_MSUBU);
`endif
    return s;
  endfunction

  function automatic logic is_div(input logic [3:0] code);
    return (code == OP_DIV) || (code == OP_DIVU);
  endfunction

  // Full 64-bit product; the low 64 bits are exact once operands are extended.
  function automatic logic [2*DATA_W-1:0] mul_full(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic sgn);
    logic signed [2*DATA_W-1:0] ea, eb, p;
    ea = sgn ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    eb = sgn ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    p  = ea * eb;
    return p;
  endfunction

  // Returns {remainder, quotient}; magnitude division keeps INT_MIN / -1 well defined.
  function automatic logic [2*DATA_W-1:0] div_full(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic sgn);
    logic              neg_a, neg_b;
    logic [DATA_W-1:0] ma, mb, q, r;
    neg_a = sgn & a[DATA_W-1];
    neg_b = sgn & b[DATA_W-1];
    ma = neg_a ? (~a + 1'b1) : a;
    mb = neg_b ? (~b + 1'b1) : b;
    if (mb == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (neg_a ^ neg_b) q = ~q + 1'b1;
    if (neg_a)         r = ~r + 1'b1;
    return {r, q};
  endfunction

  assign sgn_p0    = (op_p0 == OP_MULT) || (op_p0 == OP_DIV) ||
                     (op_p0 == OP_MADD) || (op_p0 == OP_MSUB);
  assign md_active = busy | (op_valid & is_start(op));

  always_comb begin
    prod_p0   = mul_full(src_a_p0, src_b_p0, sgn_p0);
    quot_p0   = div_full(src_a_p0, src_b_p0, sgn_p0);
    res_p0    = {hi, lo};
    res_wr_p0 = 1'b0;
    case (op_p0)
      OP_MULT, OP_MULTU: begin
        res_p0    = prod_p0;
        res_wr_p0 = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_p0    = quot_p0;
        res_wr_p0 = (src_b_p0 != '0);
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        res_p0    = {hi, lo} + prod_p0;
        res_wr_p0 = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        res_p0    = {hi, lo} - prod_p0;
        res_wr_p0 = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      op_p0    <= '0;
      src_a_p0 <= '0;
      src_b_p0 <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        // Accept boundary: operands and op latched into the _p0 stage
        IDLE: begin
          if (op_valid && is_start(op)) begin
            state    <= RUN;
            busy     <= 1'b1;
            op_p0    <= op;
            src_a_p0 <= src_a;
            src_b_p0 <= src_b;
            cnt      <= is_div(op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          end else if (op_valid && op == OP_MTHI) begin
            hi <= src_a;
          end else if (op_valid && op == OP_MTLO) begin
            lo <= src_a;
          end
        end
        // Commit boundary: result from _p0 written to HI/LO on the last busy cycle
        RUN: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (res_wr_p0) begin
              hi <= res_p0[2*DATA_W-1:DATA_W];
              lo <= res_p0[DATA_W-1:0];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO and busy length,
// a negedge monitor checks them whenever busy drops.
module tb_md_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, md_active;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .md_active(md_active),
    .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_busy = 1'b0;
  int   run_len = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int n, input string t);
    exp_t e;
    e.hi = h; e.lo = l; e.len = n; e.tag = t;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: busy still 1 after 40 cycles, want 0", name);
    end
  endtask

  // Completion monitor
  always @(negedge clk) begin
    if (busy) begin
      run_len++;
    end else if (prev_busy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_completion: hi=0x%0h lo=0x%0h, want no completion", hi, lo);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_hi"}, 64'(hi), 64'(mon_e.hi));
        check({mon_e.tag, "_lo"}, 64'(lo), 64'(mon_e.lo));
        check({mon_e.tag, "_busy_len"}, 64'(run_len), 64'(mon_e.len));
      end
      run_len = 0;
    end
    prev_busy = busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = 4'd0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_md_active", 64'(md_active), 64'h0);
    reset = 1'b0;

    issue(4'd5, 32'h12345678, 32'h0);
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_busy", 64'(busy), 64'h0);

    push(32'hFFFFFFFF, 32'hFFFFFFFE, 5, "mult");
    issue(4'd1, 32'hFFFFFFFF, 32'h00000002);
    wait_idle("mult");
    push(32'h00000001, 32'hFFFFFFFE, 5, "multu");
    issue(4'd2, 32'hFFFFFFFF, 32'h00000002);
    wait_idle("multu");

    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg");
    issue(4'd3, 32'hFFFFFFF9, 32'h00000002);
    wait_idle("div_neg");
    push(32'h00000001, 32'h00000003, 10, "divu");
    issue(4'd4, 32'h00000007, 32'h00000002);
    wait_idle("divu");
    push(32'h00000000, 32'h80000000, 10, "div_ovf");
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_ovf");

    issue(4'd5, 32'h000000AA, 32'h0);
    issue(4'd6, 32'h000000BB, 32'h0);
    push(32'h000000AA, 32'h000000BB, 10, "div_zero");
    issue(4'd3, 32'h00001234, 32'h00000000);
    wait_idle("div_zero");

    // Reset during the 4th busy cycle of a divide
    push(32'h0, 32'h0, 4, "div_abort");
    issue(4'd3, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_hi", 64'(hi), 64'h0);
    check("abort_lo", 64'(lo), 64'h0);

    // mtlo during busy is ignored; md_active tracks start and busy
    push(32'h0, 32'd12, 5, "mult_mtlo");
    @(posedge clk); #1;
    op_valid = 1'b1; op = 4'd1; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    check("start_md_active", 64'(md_active), 64'h1);
    check("start_busy", 64'(busy), 64'h0);
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0;
    @(negedge clk);
    check("run_busy", 64'(busy), 64'h1);
    check("run_md_active", 64'(md_active), 64'h1);
    issue(4'd6, 32'd5, 32'h0);
    wait_idle("mult_mtlo");
    check("done_md_active", 64'(md_active), 64'h0);
    check("mtlo_ignored_lo", 64'(lo), 64'd12);

    issue(4'd5, 32'h0, 32'h0);
    issue(4'd6, 32'hFFFFFFFF, 32'h0);
`ifdef MDU_MADD_EN
    push(32'h00000001, 32'h00000000, 5, "maddu");
`endif
    @(posedge clk); #1;
    op_valid = 1'b1; op = 4'd8; src_a = 32'd1; src_b = 32'd1;
    @(negedge clk);
`ifdef MDU_MADD_EN
    check("maddu_md_active", 64'(md_active), 64'h1);
`else
    check("maddu_md_active", 64'(md_active), 64'h0);
`endif
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0;
`ifdef MDU_MADD_EN
    wait_idle("maddu");
    push(32'h00000000, 32'hFFFFFFFF, 5, "msub");
    issue(4'd9, 32'd1, 32'd1);
    wait_idle("msub");
`else
    @(negedge clk);
    check("maddu_nop_busy", 64'(busy), 64'h0);
    check("maddu_nop_hi", 64'(hi), 64'h0);
    check("maddu_nop_lo", 64'(lo), 64'hFFFFFFFF);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
